// File: rtl/alu_rr_scheduler.sv
// Round-robin front end for a single registered add/sub ALU: grants one requester at a time,
// waits out the ALU latency, then returns the result tagged with the issuer's ID.
module alu_rr_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 1,
    parameter int OP_W        = 3,
    parameter int RES_W       = OP_W + 1,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]      req_sel,
    output logic [OP_W-1:0]         alu_a,
    output logic [OP_W-1:0]         alu_b,
    output logic                    alu_sel,
    input  logic [RES_W-1:0]        alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_result,
    output logic                    busy
);

    localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [OP_W-1:0]    alu_a_q, alu_a_d;
    logic [OP_W-1:0]    alu_b_q, alu_b_d;
    logic               alu_sel_q, alu_sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [RES_W-1:0]   rsp_result_q, rsp_result_d;

    logic [OP_W-1:0]    a_slot [NUM_REQ];
    logic [OP_W-1:0]    b_slot [NUM_REQ];
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign a_slot[gi] = req_a[gi*OP_W +: OP_W];
            assign b_slot[gi] = req_b[gi*OP_W +: OP_W];
        end
    endgenerate

    // Search starts just after the last winner, so the previous grantee has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    alu_a_d      = a_slot[grant_idx];
                    alu_b_d      = b_slot[grant_idx];
                    alu_sel_d    = req_sel[grant_idx];
                    rsp_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = CNT_W'(ALU_LATENCY);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                // Counter hits zero exactly when the ALU output reflects the held operands.
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a one-cycle registered add/sub ALU attached.
module tb_alu_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int OP_W    = 3;
    localparam int RES_W   = 4;
    localparam int ID_W    = 2;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_a = '0;
    logic [NUM_REQ*OP_W-1:0] req_b = '0;
    logic [NUM_REQ-1:0]      req_sel = '0;
    logic [OP_W-1:0]         alu_a;
    logic [OP_W-1:0]         alu_b;
    logic                    alu_sel;
    logic [RES_W-1:0]        alu_result;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b0;
    logic [ID_W-1:0]         rsp_id;
    logic [RES_W-1:0]        rsp_result;
    logic                    busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ALU_LATENCY(1), .OP_W(OP_W), .RES_W(RES_W), .ID_W(ID_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .busy(busy)
    );

    // Registered ALU sharing the scheduler's reset.
    always_ff @(posedge clock) begin
        if (reset) alu_result <= '0;
        else if (alu_sel) alu_result <= {1'b0, alu_a} - {1'b0, alu_b};
        else alu_result <= {1'b0, alu_a} + {1'b0, alu_b};
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int id, input int a, input int b, input int sel);
        req_a[id*OP_W +: OP_W] = OP_W'(a);
        req_b[id*OP_W +: OP_W] = OP_W'(b);
        req_sel[id]            = sel[0];
    endtask

    task automatic wait_ready();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("ready_timeout", 32'(ok), 1);
    endtask

    task automatic wait_rsp();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("rsp_timeout", 32'(ok), 1);
    endtask

    task automatic single_op(input int id, input int a, input int b, input int sel, input int exp_res);
        rsp_ready = 1'b1;
        req_valid = '0;
        req_valid[id] = 1'b1;
        set_op(id, a, b, sel);
        #1;
        chk("grant", req_ready, 32'(1 << id));
        tick();
        req_valid = '0;
        #1;
        chk("busy_wait", busy, 1);
        chk("ready_wait", req_ready, 0);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_sel", alu_sel, sel);
        chk("rsp_early0", rsp_valid, 0);
        tick();
        chk("rsp_early1", rsp_valid, 0);
        tick();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_result", rsp_result, exp_res);
        $display("rsp id=%0d result=%0h", rsp_id, rsp_result);
        tick();
        chk("rsp_done", rsp_valid, 0);
        chk("busy_done", busy, 0);
    endtask

    int rr_order [5] = '{0, 1, 2, 3, 0};
    int rr_res   [4] = '{4'h3, 4'h5, 4'hB, 4'hF};

    initial begin
        // Reset and idle
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);

        single_op(2, 3, 4, 0, 4'h7);
        single_op(1, 3, 5, 1, 4'hE);
        single_op(0, 7, 7, 0, 4'hE);

        // Reset while the op is waiting on the ALU
        req_valid = 4'b0001;
        set_op(0, 7, 1, 0);
        tick();
        req_valid = '0;
        chk("mid_busy", busy, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy_rst", busy, 0);
        chk("mid_rsp_rst", rsp_valid, 0);
        chk("mid_alu_a_rst", alu_a, 0);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("mid_no_rsp", rsp_valid, 0);
        end

        // Round robin with every requester asking
        set_op(0, 1, 2, 0);
        set_op(1, 6, 1, 1);
        set_op(2, 5, 6, 0);
        set_op(3, 0, 1, 1);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            wait_ready();
            chk("rr_grant", req_ready, 32'(1 << rr_order[i]));
            tick();
            chk("rr_onehot_busy", req_ready, 0);
            wait_rsp();
            chk("rr_id", rsp_id, rr_order[i]);
            chk("rr_result", rsp_result, rr_res[rr_order[i]]);
            $display("rsp id=%0d result=%0h", rsp_id, rsp_result);
            tick();
        end
        req_valid = '0;

        // Backpressure on the response channel
        rsp_ready = 1'b0;
        set_op(2, 4, 3, 1);
        set_op(0, 1, 2, 0);
        req_valid = 4'b0101;
        #1;
        chk("bp_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0001;
        tick();
        tick();
        chk("bp_valid", rsp_valid, 1);
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_id", rsp_id, 2);
            chk("bp_hold_result", rsp_result, 4'h1);
            chk("bp_hold_ready", req_ready, 0);
        end
        $display("rsp id=%0d result=%0h", rsp_id, rsp_result);
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_busy", busy, 0);
        chk("bp_next_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_rsp();
        chk("bp_next_id", rsp_id, 0);
        chk("bp_next_result", rsp_result, 4'h3);
        $display("rsp id=%0d result=%0h", rsp_id, rsp_result);
        tick();

        // Requester 3 withdraws while requester 1 keeps asking
        set_op(2, 2, 2, 0);
        req_valid = 4'b0100;
        #1;
        chk("wd_grant2", req_ready, 4'b0100);
        tick();
        set_op(3, 1, 1, 0);
        req_valid = 4'b1000;
        tick();
        set_op(1, 5, 2, 1);
        req_valid = 4'b0010;
        tick();
        chk("wd_rsp_valid", rsp_valid, 1);
        chk("wd_rsp_id", rsp_id, 2);
        chk("wd_rsp_result", rsp_result, 4'h4);
        $display("rsp id=%0d result=%0h", rsp_id, rsp_result);
        tick();
        chk("wd_grant1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        wait_rsp();
        chk("wd_id1", rsp_id, 1);
        chk("wd_result1", rsp_result, 4'h3);
        $display("rsp id=%0d result=%0h", rsp_id, rsp_result);
        tick();
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("wd_no_rsp", rsp_valid, 0);
            chk("wd_idle", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
